// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// The state encoding is fixed at 2 bits so that older code can keep comparing against the raw values.
package bus_arbiter_pkg;

  localparam int MAX_MASTERS = 16;

  typedef logic [1:0] arbState_t;

  localparam arbState_t ARB_IDLE    = 2'b00;
  localparam arbState_t ARB_GRANT   = 2'b01;
  localparam arbState_t ARB_RELEASE = 2'b10;

  function automatic logic [MAX_MASTERS-1:0] indexToOneHot(input logic [3:0] idx);
    return {{(MAX_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: the first request found after lastOwner wins.
// If nothing is requested, the winner output repeats lastOwner.
module rr_priority_picker #(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]   lastOwner,
  output logic                 found,
  output logic [OWNER_W-1:0]   winner
);

  typedef logic [OWNER_W:0] idx_t;

  idx_t idx;

  // One spare bit in idx keeps lastOwner+k from overflowing before it is wrapped back below N_MASTERS.
  always_comb begin
    found  = 1'b0;
    winner = lastOwner;
    idx    = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = {1'b0, lastOwner} + idx_t'(k);
      if (idx >= idx_t'(N_MASTERS)) begin
        idx = idx - idx_t'(N_MASTERS);
      end
      if (!found && req[idx[OWNER_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared memory bus. A grant is held while its owner keeps requesting.
// Each grant is followed by a release phase that waits for memory to drop Ready.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] Bus_RQ,
  input  logic                 Bus_Ready,
  output logic [N_MASTERS-1:0] Bus_GRANT,
  output logic [OWNER_W-1:0]   Bus_Owner,
  output logic                 Bus_Busy
);

  arbState_t          state;
  arbState_t          nextState;
  logic [OWNER_W-1:0] lastOwner;
  logic               found;
  logic [OWNER_W-1:0] winner;
  logic               ownerRq;

  rr_priority_picker #(
    .N_MASTERS(N_MASTERS),
    .OWNER_W  (OWNER_W)
  ) picker (
    .req      (Bus_RQ),
    .lastOwner(lastOwner),
    .found    (found),
    .winner   (winner)
  );

  assign ownerRq = Bus_RQ[Bus_Owner];

  always_comb begin
    nextState = ARB_IDLE;
    case (state)
      ARB_IDLE:    nextState = found ? ARB_GRANT : ARB_IDLE;
      ARB_GRANT:   nextState = ownerRq ? ARB_GRANT : ARB_RELEASE;
      ARB_RELEASE: nextState = Bus_Ready ? ARB_RELEASE : ARB_IDLE;
      default:     nextState = ARB_IDLE;
    endcase
  end

  // Requests from non-owners are ignored outside IDLE, so they are served only after the release phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      Bus_GRANT <= '0;
      Bus_Busy  <= 1'b0;
      Bus_Owner <= OWNER_W'(N_MASTERS - 1);
      lastOwner <= OWNER_W'(N_MASTERS - 1);
    end else begin
      state    <= nextState;
      Bus_Busy <= (nextState != ARB_IDLE);
      if (state == ARB_IDLE && found) begin
        Bus_GRANT <= N_MASTERS'(indexToOneHot(4'(winner)));
        Bus_Owner <= winner;
        lastOwner <= winner;
      end else if (nextState != ARB_GRANT) begin
        Bus_GRANT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. A behavioural model tracks the holder, the release phase and the pointer.
// Every cycle is compared against that model, and literal expectations pin down the model itself.
module tb_bus_arbiter;

  localparam int N = 4;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] Bus_RQ;
  logic         Bus_Ready;
  logic [N-1:0] Bus_GRANT;
  logic [W-1:0] Bus_Owner;
  logic         Bus_Busy;

  int checks = 0;
  int errors = 0;

  int         order[5] = '{0, 1, 2, 3, 0};
  logic [2:0] noise[8] = '{3'b111, 3'b000, 3'b101, 3'b010, 3'b001, 3'b110, 3'b011, 3'b100};

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .Bus_RQ   (Bus_RQ),
    .Bus_Ready(Bus_Ready),
    .Bus_GRANT(Bus_GRANT),
    .Bus_Owner(Bus_Owner),
    .Bus_Busy (Bus_Busy)
  );

  // Model: holder index, or -1 when nobody holds the bus; a releasing flag; and a rotating pointer.
  int mHolder = -1;
  bit mRel    = 1'b0;
  int mPtr    = N - 1;
  int mOwner  = N - 1;

  function automatic int pickWinner(input logic [N-1:0] rq, input int ptr);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (w < 0 && rq[W'(c)]) w = c;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] modelGrant();
    return (mHolder >= 0) ? (N'(1) << mHolder) : '0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHolder <= -1;
      mRel    <= 1'b0;
      mPtr    <= N - 1;
      mOwner  <= N - 1;
    end else if (mHolder >= 0) begin
      if (!Bus_RQ[W'(mHolder)]) begin
        mHolder <= -1;
        mRel    <= 1'b1;
      end
    end else if (mRel) begin
      if (!Bus_Ready) mRel <= 1'b0;
    end else if (pickWinner(Bus_RQ, mPtr) >= 0) begin
      mHolder <= pickWinner(Bus_RQ, mPtr);
      mPtr    <= pickWinner(Bus_RQ, mPtr);
      mOwner  <= pickWinner(Bus_RQ, mPtr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] g, input int o, input logic b);
    check({name, ".grant"}, 32'(Bus_GRANT), 32'(g));
    check({name, ".owner"}, 32'(Bus_Owner), 32'(o));
    check({name, ".busy"},  32'(Bus_Busy),  32'(b));
  endtask

  task automatic applyStimulus(input logic [N-1:0] rq, input logic rdy);
    Bus_RQ    = rq;
    Bus_Ready = rdy;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset();
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitGrant(input string name);
    for (int c = 0; c < 10 && Bus_GRANT == '0; c++) step(1);
    checks++;
    if (Bus_GRANT == '0) begin
      errors++;
      $display("[TB] FAIL %s: no grant within 10 cycles, grant=%b", name, Bus_GRANT);
    end
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 20 && (Bus_Busy !== 1'b0 || Bus_GRANT !== '0); c++) step(1);
    checks++;
    if (Bus_Busy !== 1'b0 || Bus_GRANT !== '0) begin
      errors++;
      $display("[TB] FAIL %s: not idle within 20 cycles, busy=%b grant=%b", name, Bus_Busy, Bus_GRANT);
    end
  endtask

  // Per-cycle comparison against the model, plus the one-hot and grant-gap invariants.
  logic [N-1:0] prevG     = '0;
  int           gapZeros  = 0;
  bit           seenGrant = 1'b0;

  always @(negedge clk) begin
    check("model.grant", 32'(Bus_GRANT), 32'(modelGrant()));
    check("model.owner", 32'(Bus_Owner), 32'(mOwner));
    check("model.busy",  32'(Bus_Busy),  32'(mHolder >= 0 || mRel));
    checks++;
    assert ($onehot0(Bus_GRANT)) else begin
      errors++;
      $display("[TB] FAIL onehot0: grant=%b at %0t", Bus_GRANT, $time);
    end
    if (!reset) begin
      seenGrant <= 1'b0;
      gapZeros  <= 0;
    end else if (Bus_GRANT == '0) begin
      gapZeros <= gapZeros + 1;
    end else begin
      if (prevG == '0 && seenGrant) check("grantGap", 32'(gapZeros >= 2), 32'd1);
      seenGrant <= 1'b1;
      gapZeros  <= 0;
    end
    prevG <= Bus_GRANT;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus('0, 1'b0);
    reset = 1'b0;
    step(2);
    checkOutput("reset", 4'b0000, 3, 1'b0);
    reset = 1'b1;

    $display("[TB] single request");
    applyStimulus(4'b0001, 1'b0);
    step(1);
    checkOutput("single_grant", 4'b0001, 0, 1'b1);
    step(1);
    checkOutput("single_hold", 4'b0001, 0, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    step(1);
    checkOutput("single_release", 4'b0000, 0, 1'b1);
    step(1);
    checkOutput("single_idle", 4'b0000, 0, 1'b0);

    $display("[TB] rotation");
    pulseReset();
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      waitGrant("rot_wait");
      checkOutput("rot", N'(1) << order[i], order[i], 1'b1);
      step(2);
      applyStimulus(Bus_RQ & ~(N'(1) << order[i]), 1'b0);
      waitIdle("rot_idle");
      if (i < 4) applyStimulus(4'b1111, 1'b0);
    end

    $display("[TB] pointer fairness");
    applyStimulus(4'b0100, 1'b0);
    step(1);
    checkOutput("fair_setup", 4'b0100, 2, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    step(2);
    checkOutput("fair_idle", 4'b0000, 2, 1'b0);
    applyStimulus(4'b0101, 1'b0);
    step(1);
    checkOutput("fair_first", 4'b0001, 0, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    step(2);
    applyStimulus(4'b0101, 1'b0);
    step(1);
    checkOutput("fair_second", 4'b0100, 2, 1'b1);

    $display("[TB] ready hold-off");
    applyStimulus(4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      checkOutput("holdoff", 4'b0000, 2, 1'b1);
    end
    applyStimulus(4'b0001, 1'b0);
    step(1);
    checkOutput("holdoff_idle", 4'b0000, 2, 1'b0);
    step(1);
    checkOutput("holdoff_grant", 4'b0001, 0, 1'b1);

    $display("[TB] async reset mid-grant");
    applyStimulus(4'b0000, 1'b0);
    step(2);
    applyStimulus(4'b0100, 1'b0);
    step(1);
    checkOutput("pre_reset", 4'b0100, 2, 1'b1);
    #2 reset = 1'b0;
    applyStimulus(4'b0110, 1'b0);
    #1 checkOutput("async_reset", 4'b0000, 3, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset", 4'b0010, 1, 1'b1);

    $display("[TB] non-owner noise");
    applyStimulus(4'b0000, 1'b0);
    step(2);
    applyStimulus(4'b1000, 1'b0);
    step(1);
    checkOutput("noise_grant", 4'b1000, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus({1'b1, noise[i]}, 1'b0);
      step(1);
      checkOutput("noise", 4'b1000, 3, 1'b1);
    end
    applyStimulus(4'b0000, 1'b0);
    step(2);
    checkOutput("noise_done", 4'b0000, 3, 1'b0);

    $display("[TB] request withdrawn before sampling");
    applyStimulus(4'b0010, 1'b0);
    #2 applyStimulus(4'b0000, 1'b0);
    step(1);
    checkOutput("withdrawn", 4'b0000, 3, 1'b0);
    step(1);
    checkOutput("withdrawn2", 4'b0000, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
